// File: rtl/mac_array_sequencer_if.sv
// Memory read bus between the MAC-array sequencer (master) and a word-wide
// memory with waitrequest and a separate readdatavalid (slave).
interface mac_array_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 64
);
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_waitrequest;
  logic [WORD_WIDTH-1:0] mem_readdata;
  logic                  mem_readdatavalid;

  modport master (
    output mem_read,
    output mem_addr,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_read,
    input  mem_addr,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

// File: rtl/mac_array_sequencer.sv
// Loads ROWS matrix rows plus one vector row from memory into per-row FIFOs,
// then drains them into the MAC array in a staggered systolic schedule.
module mac_array_sequencer #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  mac_array_sequencer_if.master    mem,
  output logic [DATA_WIDTH-1:0]    fifo_wdata,
  output logic [ROWS:0]            wren,
  output logic [ROWS:0]            rden,
  input  logic [ROWS:0]            full,
  input  logic [ROWS:0]            empty,
  output logic                     mac_clr,
  output logic [ROWS-1:0]          mac_en,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RowW   = $clog2(ROWS + 1);
  localparam int unsigned ElemW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned KW     = $clog2(DEPTH + ROWS);
  localparam int unsigned LastK  = DEPTH + ROWS - 2;
  localparam int unsigned DrainW = $clog2(MAC_LATENCY + 2);
  localparam int          DepthI = int'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFill,
    StCompute,
    StDrain,
    StDone
  } state_e;

  state_e                               state_q, state_d;
  logic [RowW-1:0]                      row_q, row_d;
  logic [ElemW-1:0]                     elem_q, elem_d;
  logic [KW-1:0]                        k_q, k_d;
  logic [DrainW-1:0]                    drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]                base_q, base_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     data_q, data_d;
  logic                                 mac_clr_q, mac_clr_d;
  logic [ROWS-1:0]                      mac_en_q, mac_en_d;
  logic [ROWS:0]                        sched;

  // A row r enters the array r cycles after row 0; B streams from k=0.
  always_comb begin
    sched = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      sched[r] = (int'(k_q) >= r) && (int'(k_q) < r + DepthI);
    end
    sched[ROWS] = int'(k_q) < DepthI;
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    elem_d       = elem_q;
    k_d          = k_q;
    drain_d      = drain_q;
    base_d       = base_q;
    data_d       = data_q;
    mac_clr_d    = 1'b0;
    mem.mem_read = 1'b0;
    mem.mem_addr = '0;
    fifo_wdata   = '0;
    wren         = '0;
    rden         = '0;
    busy         = (state_q != StIdle);
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mac_clr_d = 1'b1;
          row_d     = '0;
          base_d    = base_addr;
          state_d   = StReq;
        end
      end
      StReq: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = base_q + ADDR_WIDTH'(row_q);
        if (!mem.mem_waitrequest) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem.mem_readdatavalid) begin
          data_d  = mem.mem_readdata;
          elem_d  = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        fifo_wdata = data_q[elem_q];
        if (!full[row_q]) begin
          wren[row_q] = 1'b1;
          elem_d      = elem_q + 1'b1;
          if (elem_q == ElemW'(DEPTH - 1)) begin
            if (row_q == RowW'(ROWS)) begin
              k_d     = '0;
              state_d = StCompute;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = StReq;
            end
          end
        end
      end
      StCompute: begin
        // Advance only when every FIFO due this step can supply a word.
        if ((sched & empty) == '0) begin
          rden = sched;
          if (k_q == KW'(LastK)) begin
            drain_d = '0;
            state_d = StDrain;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(MAC_LATENCY)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // FIFO data appears one cycle after rden, so the MAC fires then.
    mac_en_d = rden[ROWS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      row_q     <= '0;
      elem_q    <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      base_q    <= '0;
      data_q    <= '0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      elem_q    <= elem_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      base_q    <= base_d;
      data_q    <= data_d;
      mac_clr_q <= mac_clr_d;
      mac_en_q  <= mac_en_d;
    end
  end

  assign mac_clr = mac_clr_q;
  assign mac_en  = mac_en_q;

  wren_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wren));
  wr_rd_excl_a: assert property (@(posedge clk) disable iff (!rst_n) !((|wren) && (|rden)));
  req_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (mem.mem_read && mem.mem_waitrequest) |=> (mem.mem_read && $stable(mem.mem_addr)));
  done_idle_a: assert property (@(posedge clk) disable iff (!rst_n) done |=> !busy);

endmodule
